// File: rtl/evo_pmux_pkg.sv
`default_nettype none
// ============================================================================
// Package  : evo_pmux_pkg
// Brief    : Shared offsets, CTL/STS bit indices and status type for pin-mux CSRs
// Revision : 1.0
// ============================================================================
package evo_pmux_pkg;

    localparam logic [3:0] PMUX_OFS_CTL   = 4'd1;
    localparam logic [3:0] PMUX_OFS_STS   = 4'd2;
    localparam logic [3:0] PMUX_OFS_WRADR = 4'd3;
    localparam logic [3:0] PMUX_OFS_DIR   = 4'd4;
    localparam logic [3:0] PMUX_OFS_OUT   = 4'd5;
    localparam logic [3:0] PMUX_OFS_EN    = 4'd6;
    localparam logic [3:0] PMUX_OFS_IN    = 4'd7;
    localparam logic [3:0] PMUX_OFS_SEL   = 4'd8;

    localparam int PMUX_CTL_COMMIT  = 0;
    localparam int PMUX_CTL_AUTOINC = 1;
    localparam int PMUX_CTL_IRQEN   = 2;
    localparam int PMUX_CTL_REVERT  = 3;

    localparam int PMUX_STS_PENDING = 0;
    localparam int PMUX_STS_CHG     = 1;
    localparam int PMUX_STS_WRAP    = 2;

    typedef struct packed {
        logic wrap;
        logic chg;
        logic pending;
    } pmux_sts_t;

endpackage
`default_nettype wire

// File: rtl/evo_pmux_port.sv
`default_nettype none
// ============================================================================
// Module   : evo_pmux_port
// Brief    : One pin-mux port bank: shadow/live pin regs, select table, input sync
// Revision : 1.0
// ============================================================================
module evo_pmux_port
    import evo_pmux_pkg::*;
#(
    parameter int PINS = 8,
    parameter int SELW = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [3:0]           ofs,
    input  logic [31:0]          wdata,
    input  logic [PINS-1:0]      pin_in,
    output logic [31:0]          rdata,
    output logic [PINS-1:0]      pin_out,
    output logic [PINS-1:0]      pin_oe,
    output logic [PINS-1:0]      pin_en,
    output logic [PINS*SELW-1:0] sel,
    output logic                 irq_req
);

    localparam int              PTRW       = (PINS > 1) ? $clog2(PINS) : 1;
    localparam logic [PTRW-1:0] c_ptr_last = PTRW'(PINS - 1);
    localparam logic [31:0]     c_pins     = 32'(PINS);

    logic            r_autoinc;
    logic            r_irqen;
    logic [PINS-1:0] r_shd_dir, r_shd_out, r_shd_en;
    logic [PINS-1:0] r_live_dir, r_live_out, r_live_en;
    logic [PTRW-1:0] r_wradr;
    logic [SELW-1:0] r_sel [PINS];
    logic [PINS-1:0] r_sync1, r_sync2, r_sync3;
    pmux_sts_t       r_sts;

    logic        w_wr_ctl, w_wr_sts, w_wr_wradr, w_wr_dir, w_wr_out, w_wr_en, w_wr_sel;
    logic        w_commit, w_revert, w_shadow_wr;
    logic        w_chg_evt, w_wrap_evt;
    logic [31:0] w_wradr_mod;
    logic        w_unused_wdata;

    assign w_wr_ctl    = wr_en && (ofs == PMUX_OFS_CTL);
    assign w_wr_sts    = wr_en && (ofs == PMUX_OFS_STS);
    assign w_wr_wradr  = wr_en && (ofs == PMUX_OFS_WRADR);
    assign w_wr_dir    = wr_en && (ofs == PMUX_OFS_DIR);
    assign w_wr_out    = wr_en && (ofs == PMUX_OFS_OUT);
    assign w_wr_en     = wr_en && (ofs == PMUX_OFS_EN);
    assign w_wr_sel    = wr_en && (ofs == PMUX_OFS_SEL);
    assign w_shadow_wr = w_wr_dir | w_wr_out | w_wr_en;

    // COMMIT takes priority when both action bits arrive in one write
    assign w_commit = w_wr_ctl & wdata[PMUX_CTL_COMMIT];
    assign w_revert = w_wr_ctl & wdata[PMUX_CTL_REVERT] & ~wdata[PMUX_CTL_COMMIT];

    assign w_wradr_mod    = {27'd0, wdata[4:0]} % c_pins;
    assign w_chg_evt      = |(r_sync2 ^ r_sync3);
    assign w_wrap_evt     = w_wr_sel & r_autoinc & (r_wradr == c_ptr_last);
    assign w_unused_wdata = ^wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_autoinc <= 1'b0;
            r_irqen   <= 1'b0;
        end else if (w_wr_ctl) begin
            r_autoinc <= wdata[PMUX_CTL_AUTOINC];
            r_irqen   <= wdata[PMUX_CTL_IRQEN];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shd_dir  <= '0;
            r_shd_out  <= '0;
            r_shd_en   <= '0;
            r_live_dir <= '0;
            r_live_out <= '0;
            r_live_en  <= '0;
        end else begin
            if (w_commit) begin
                r_live_dir <= r_shd_dir;
                r_live_out <= r_shd_out;
                r_live_en  <= r_shd_en;
            end
            if (w_revert) begin
                r_shd_dir <= r_live_dir;
                r_shd_out <= r_live_out;
                r_shd_en  <= r_live_en;
            end else begin
                if (w_wr_dir) r_shd_dir <= wdata[PINS-1:0];
                if (w_wr_out) r_shd_out <= wdata[PINS-1:0];
                if (w_wr_en)  r_shd_en  <= wdata[PINS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wradr <= '0;
            for (int i = 0; i < PINS; i++) r_sel[i] <= '0;
        end else if (w_wr_wradr) begin
            r_wradr <= w_wradr_mod[PTRW-1:0];
        end else if (w_wr_sel) begin
            r_sel[r_wradr] <= wdata[SELW-1:0];
            if (r_autoinc) begin
                r_wradr <= (r_wradr == c_ptr_last) ? '0 : r_wradr + 1'b1;
            end
        end
    end

    // Stages 1-2 synchronise the pads; stage 3 is the change-detect reference
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= pin_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sts <= '0;
        end else begin
            if (w_shadow_wr) begin
                r_sts.pending <= 1'b1;
            end else if (w_commit | w_revert) begin
                r_sts.pending <= 1'b0;
            end
            r_sts.chg  <= w_chg_evt  | (r_sts.chg  & ~(w_wr_sts & wdata[PMUX_STS_CHG]));
            r_sts.wrap <= w_wrap_evt | (r_sts.wrap & ~(w_wr_sts & wdata[PMUX_STS_WRAP]));
        end
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            PMUX_OFS_CTL: begin
                rdata[PMUX_CTL_AUTOINC] = r_autoinc;
                rdata[PMUX_CTL_IRQEN]   = r_irqen;
            end
            PMUX_OFS_STS:   rdata[2:0]      = r_sts;
            PMUX_OFS_WRADR: rdata[PTRW-1:0] = r_wradr;
            PMUX_OFS_DIR:   rdata[PINS-1:0] = r_shd_dir;
            PMUX_OFS_OUT:   rdata[PINS-1:0] = r_shd_out;
            PMUX_OFS_EN:    rdata[PINS-1:0] = r_shd_en;
            PMUX_OFS_IN:    rdata[PINS-1:0] = r_sync2;
            PMUX_OFS_SEL:   rdata[SELW-1:0] = r_sel[r_wradr];
            default:        rdata           = '0;
        endcase
    end

    generate
        for (genvar i = 0; i < PINS; i++) begin : g_sel
            assign sel[i*SELW +: SELW] = r_sel[i];
        end
    endgenerate

    assign pin_out = r_live_out;
    assign pin_oe  = r_live_dir;
    assign pin_en  = r_live_en;
    assign irq_req = r_sts.chg & r_irqen;

endmodule
`default_nettype wire

// File: rtl/evo_pmux_csr_array.sv
`default_nettype none
// ============================================================================
// Module   : evo_pmux_csr_array
// Brief    : NPORTS pin-mux CSR banks on the XB CSR bus: decode, read return, irq
// Revision : 1.0
// ============================================================================
module evo_pmux_csr_array
    import evo_pmux_pkg::*;
#(
    parameter int          NPORTS      = 5,
    parameter int          PINS        = 8,
    parameter int          SELW        = 2,
    parameter logic [11:0] BASE_ADDR   = 12'h910,
    parameter logic [11:0] PORT_STRIDE = 12'h010
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [11:0]                 csr_addr,
    input  logic                        csr_wr,
    input  logic                        csr_rd,
    input  logic [31:0]                 csr_wdata,
    output logic [31:0]                 csr_rdata,
    output logic                        csr_rvalid,
    input  logic [NPORTS*PINS-1:0]      pin_in,
    output logic [NPORTS*PINS-1:0]      pin_out,
    output logic [NPORTS*PINS-1:0]      pin_oe,
    output logic [NPORTS*PINS-1:0]      pin_en,
    output logic [NPORTS*PINS*SELW-1:0] pmux_sel,
    output logic                        irq
);

    logic [11:0]       w_rel;
    logic [NPORTS-1:0] w_hit;
    logic [NPORTS-1:0] w_bank_irq;
    logic [31:0]       w_bank_rdata [NPORTS];
    logic [31:0]       w_rd_mux;

    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic              r_irq;

    assign w_rel = csr_addr - BASE_ADDR;

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_bank
            localparam logic [11:0] c_lo = 12'(p) * PORT_STRIDE;

            // Addresses below the bank base wrap to large values and miss
            logic [11:0] w_bank_rel;
            assign w_bank_rel = w_rel - c_lo;
            assign w_hit[p]   = (w_bank_rel >= 12'd1) && (w_bank_rel <= 12'd8);

            evo_pmux_port #(
                .PINS (PINS),
                .SELW (SELW)
            ) u_port (
                .clk     (clk),
                .rstn    (rstn),
                .wr_en   (csr_wr & w_hit[p]),
                .ofs     (w_bank_rel[3:0]),
                .wdata   (csr_wdata),
                .pin_in  (pin_in[p*PINS +: PINS]),
                .rdata   (w_bank_rdata[p]),
                .pin_out (pin_out[p*PINS +: PINS]),
                .pin_oe  (pin_oe[p*PINS +: PINS]),
                .pin_en  (pin_en[p*PINS +: PINS]),
                .sel     (pmux_sel[p*PINS*SELW +: PINS*SELW]),
                .irq_req (w_bank_irq[p])
            );
        end
    endgenerate

    always_comb begin
        w_rd_mux = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_hit[p]) w_rd_mux = w_rd_mux | w_bank_rdata[p];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (csr_rd) r_rdata <= w_rd_mux;
            r_rvalid <= csr_rd;
            r_irq    <= |w_bank_irq;
        end
    end

    assign csr_rdata  = r_rdata;
    assign csr_rvalid = r_rvalid;
    assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_evo_pmux_csr_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_evo_pmux_csr_array
// Brief    : Directed self-checking bench for evo_pmux_csr_array
// Revision : 1.0
// ============================================================================
module tb_evo_pmux_csr_array;

    localparam int NPORTS = 5;
    localparam int PINS   = 8;
    localparam int SELW   = 2;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic [11:0]                 csr_addr;
    logic                        csr_wr;
    logic                        csr_rd;
    logic [31:0]                 csr_wdata;
    logic [31:0]                 csr_rdata;
    logic                        csr_rvalid;
    logic [NPORTS*PINS-1:0]      pin_in;
    logic [NPORTS*PINS-1:0]      pin_out;
    logic [NPORTS*PINS-1:0]      pin_oe;
    logic [NPORTS*PINS-1:0]      pin_en;
    logic [NPORTS*PINS*SELW-1:0] pmux_sel;
    logic                        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    evo_pmux_csr_array #(
        .NPORTS      (NPORTS),
        .PINS        (PINS),
        .SELW        (SELW),
        .BASE_ADDR   (12'h910),
        .PORT_STRIDE (12'h010)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .csr_addr   (csr_addr),
        .csr_wr     (csr_wr),
        .csr_rd     (csr_rd),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_rvalid (csr_rvalid),
        .pin_in     (pin_in),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe),
        .pin_en     (pin_en),
        .pmux_sel   (pmux_sel),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; the write lands on the following posedge
    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wr    = 1'b1;
        @(negedge clk);
        csr_wr    = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic v);
        csr_addr = a;
        csr_rd   = 1'b1;
        @(negedge clk);
        csr_rd   = 1'b0;
        d = csr_rdata;
        v = csr_rvalid;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        csr_read(a, d, v);
        check(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        v;
        int          cyc;

        rstn      = 1'b0;
        csr_addr  = '0;
        csr_wr    = 1'b0;
        csr_rd    = 1'b0;
        csr_wdata = '0;
        pin_in    = '0;
        repeat (3) @(negedge clk);
        check("rst_oe", pin_oe, 0);
        check("rst_sel", pmux_sel, 0);
        check("rst_rvalid", csr_rvalid, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 1; i <= 8; i++) rd_check("rst_reg", 12'(12'h910 + i), 32'h0);

        // Shadowed commit on bank 0
        csr_write(12'h914, 32'hF0);
        csr_write(12'h915, 32'hA5);
        check("shadow_oe", pin_oe[7:0], 8'h00);
        rd_check("sts_pending", 12'h912, 32'h1);
        rd_check("dir_shadow", 12'h914, 32'hF0);
        csr_write(12'h911, 32'h1);
        check("commit_oe", pin_oe[7:0], 8'hF0);
        check("commit_out", pin_out[7:0], 8'hA5);
        rd_check("sts_after_commit", 12'h912, 32'h0);
        rd_check("ctl_commit_rd0", 12'h911, 32'h0);

        // Revert on bank 1, then commit+revert together
        csr_write(12'h924, 32'h0F);
        csr_write(12'h921, 32'h8);
        rd_check("revert_dir", 12'h924, 32'h0);
        rd_check("revert_sts", 12'h922, 32'h0);
        check("revert_oe", pin_oe[15:8], 8'h00);
        csr_write(12'h924, 32'h3C);
        csr_write(12'h921, 32'h9);
        check("commit_wins", pin_oe[15:0], 16'h3CF0);
        rd_check("commit_wins_dir", 12'h924, 32'h3C);

        // Auto-increment with wrap on bank 0
        csr_write(12'h911, 32'h2);
        csr_write(12'h913, 32'h6);
        csr_write(12'h918, 32'h1);
        csr_write(12'h918, 32'h2);
        csr_write(12'h918, 32'h3);
        check("sel_table", pmux_sel[15:0], 16'h9003);
        rd_check("wradr_after", 12'h913, 32'h1);
        rd_check("ctl_autoinc", 12'h911, 32'h2);
        rd_check("sts_wrap", 12'h912, 32'h4);
        csr_write(12'h912, 32'h4);
        rd_check("sts_wrap_w1c", 12'h912, 32'h0);
        csr_write(12'h913, 32'h0);
        rd_check("sel_read", 12'h918, 32'h3);
        csr_write(12'h913, 32'd13);
        rd_check("wradr_mod", 12'h913, 32'h5);

        // Change detect and irq on bank 4
        csr_write(12'h951, 32'h4);
        pin_in[32] = 1'b1;
        cyc = 0;
        while (irq !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("irq_latency", cyc, 4);
        rd_check("chg_sts", 12'h952, 32'h2);
        rd_check("in_read", 12'h957, 32'h1);
        pin_in[32] = 1'b0;
        repeat (2) @(negedge clk);
        csr_write(12'h952, 32'h2);
        rd_check("chg_set_wins", 12'h952, 32'h2);
        csr_write(12'h952, 32'h2);
        rd_check("chg_w1c", 12'h952, 32'h0);
        check("irq_clear", irq, 0);

        // Decode and read latency
        csr_read(12'h914, d, v);
        check("rd_valid", v, 1);
        check("rd_data", d, 32'hF0);
        @(negedge clk);
        check("rvalid_pulse", csr_rvalid, 0);
        check("rdata_hold", csr_rdata, 32'hF0);
        csr_read(12'h919, d, v);
        check("unhit_valid", v, 1);
        check("unhit_data", d, 32'h0);
        rd_check("unhit_base", 12'h910, 32'h0);
        csr_write(12'h8FF, 32'hFF);
        rd_check("unhit_wr_dir", 12'h914, 32'hF0);
        rd_check("unhit_wr_sts", 12'h912, 32'h0);
        check("unhit_wr_oe", pin_oe[15:0], 16'h3CF0);

        // Reset in the middle of traffic
        csr_write(12'h915, 32'h0F);
        csr_addr = 12'h914;
        csr_rd   = 1'b1;
        @(negedge clk);
        csr_rd = 1'b0;
        check("pre_rst_rvalid", csr_rvalid, 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_oe", pin_oe, 0);
        check("mid_rst_out", pin_out, 0);
        check("mid_rst_en", pin_en, 0);
        check("mid_rst_sel", pmux_sel, 0);
        check("mid_rst_rvalid", csr_rvalid, 0);
        check("mid_rst_rdata", csr_rdata, 0);
        check("mid_rst_irq", irq, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd_check("post_rst_out", 12'h915, 32'h0);
        rd_check("post_rst_sts", 12'h912, 32'h0);
        rd_check("post_rst_ctl", 12'h951, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
